// File: rtl/net_pattern_driver_if.sv
// Pattern-word handshake bundle between an upstream source and net_pattern_driver.
// Ports: in_valid/in_data/in_repeat from the source, in_ready back to it.
// WIDTH must match the WIDTH of the net_pattern_driver this bundle is connected to.
interface net_pattern_driver_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;    // bit 0 goes onto the net first
  logic [3:0]       in_repeat;  // extra passes; total passes = in_repeat + 1

  // Source side: offers a word and holds it until in_ready is seen at an edge.
  modport master (
    output in_valid,
    output in_data,
    output in_repeat,
    input  in_ready
  );

  // Driver side: accepts a word only while idle.
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_repeat,
    output in_ready
  );

endinterface

// File: rtl/net_pattern_driver.sv
// Purpose: registered serial pattern source for a fanout net, LSB-first, repeated
//   (in_repeat+1) passes, then GAP quiet cycles; counts loopback mismatches.
// Latency: bit 0 is on net_out the cycle after acceptance; done pulses
//   WIDTH*(in_repeat+1)+GAP cycles after the first shift cycle.
// Backpressure: in_ready is high only in IDLE; a word offered while busy is left
//   in place by the source until the done cycle, when it can be taken.
// Ports: clk, rst_n (sync, active low); up (handshake bundle, slave side);
//   net_out (registered net drive), net_fb (loopback of the net);
//   busy, done (one-cycle pulse), err_cnt (saturating mismatch count).
module net_pattern_driver #(
  parameter int WIDTH = 8,   // pattern word width, 2..32
  parameter int GAP   = 2    // quiet cycles after each burst, 0..15
) (
  input  logic                clk,
  input  logic                rst_n,
  net_pattern_driver_if.slave up,
  output logic                net_out,
  input  logic                net_fb,
  output logic                busy,
  output logic                done,
  output logic [7:0]          err_cnt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_nxt;
  logic [3:0]       pass_cnt, pass_nxt;
  logic [3:0]       gap_cnt, gap_nxt;
  logic [7:0]       err_q, err_nxt;
  logic             net_q, net_nxt;
  logic             done_q, done_nxt;

  // Next-state and datapath decode.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bit_nxt   = bit_cnt;
    pass_nxt  = pass_cnt;
    gap_nxt   = gap_cnt;
    err_nxt   = err_q;
    net_nxt   = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (up.in_valid) begin
          sreg_nxt  = up.in_data;
          pass_nxt  = up.in_repeat;
          bit_nxt   = '0;
          gap_nxt   = 4'd0;
          err_nxt   = 8'd0;
          // net_out is a flop, so the first bit is loaded together with the word.
          net_nxt   = up.in_data[0];
          state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Rotate rather than shift so the word is intact after every pass.
        sreg_nxt = {sreg[0], sreg[WIDTH-1:1]};

        // net_q is what is on the net this cycle; net_fb must agree with it.
        if ((net_fb != net_q) && (err_q != 8'hFF)) begin
          err_nxt = err_q + 8'd1;
        end

        if (bit_cnt == BIT_LAST) begin
          bit_nxt = '0;
          if (pass_cnt == 4'd0) begin
            if (GAP > 0) begin
              state_nxt = ST_GAP;
            end else begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            pass_nxt = pass_cnt - 4'd1;
            // After WIDTH-1 rotations, bit 1 holds the original bit 0.
            net_nxt  = sreg[1];
          end
        end else begin
          bit_nxt = bit_cnt + CW'(1);
          net_nxt = sreg[1];
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = 4'd0;
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          gap_nxt = gap_cnt + 4'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst without a done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      pass_cnt <= 4'd0;
      gap_cnt  <= 4'd0;
      err_q    <= 8'd0;
      net_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      bit_cnt  <= bit_nxt;
      pass_cnt <= pass_nxt;
      gap_cnt  <= gap_nxt;
      err_q    <= err_nxt;
      net_q    <= net_nxt;
      done_q   <= done_nxt;
    end
  end

  // Outputs come from flops or state decode only.
  assign up.in_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign net_out     = net_q;
  assign done        = done_q;
  assign err_cnt     = err_q;

  // done is raised on entry to IDLE, so the driver is always ready then.
  a_done_ready : assert property (@(posedge clk) disable iff (!rst_n) done |-> up.in_ready);
  // Outside SHIFT the net is held low.
  a_quiet_net : assert property (@(posedge clk) disable iff (!rst_n)
                                 (state != ST_SHIFT) |-> !net_out);

endmodule

// File: tb/tb_net_pattern_driver.sv
// Directed bench for net_pattern_driver: three instances cover WIDTH=8/GAP=2,
// WIDTH=32/GAP=2 (err_cnt saturation) and WIDTH=8/GAP=0 (back-to-back bursts).
module tb_net_pattern_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, GAP=2
  net_pattern_driver_if #(.WIDTH(8)) if8 ();
  logic       net8, busy8, done8, fb8, fb8_force, fb8_val;
  logic [7:0] err8;
  assign fb8 = fb8_force ? fb8_val : net8;

  net_pattern_driver #(.WIDTH(8), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .up(if8.slave), .net_out(net8), .net_fb(fb8),
    .busy(busy8), .done(done8), .err_cnt(err8)
  );

  // Instance B: WIDTH=32, GAP=2, loopback stuck at 0
  net_pattern_driver_if #(.WIDTH(32)) if32 ();
  logic       net32, busy32, done32, fb32;
  logic [7:0] err32;

  net_pattern_driver #(.WIDTH(32), .GAP(2)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .up(if32.slave), .net_out(net32), .net_fb(fb32),
    .busy(busy32), .done(done32), .err_cnt(err32)
  );

  // Instance C: WIDTH=8, GAP=0, loopback tied to the net
  net_pattern_driver_if #(.WIDTH(8)) ifg0 ();
  logic       netg0, busyg0, doneg0;
  logic [7:0] errg0;

  net_pattern_driver #(.WIDTH(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .up(ifg0.slave), .net_out(netg0), .net_fb(netg0),
    .busy(busyg0), .done(doneg0), .err_cnt(errg0)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    checks++; if (net8 !== 1'b0) begin errors++; $display("FAIL reset_net got %b exp 0", net8); end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", if8.in_ready); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
    checks++; if (err8 !== 8'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err8); end
    checks++; if (err32 !== 8'd0 || busy32 !== 1'b0 || busyg0 !== 1'b0) begin
      errors++; $display("FAIL reset_others got err32=%0d busy32=%b busyg0=%b exp 0/0/0", err32, busy32, busyg0);
    end
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (net8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 || if8.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_quiet cyc %0d got net=%b busy=%b done=%b rdy=%b exp 0/0/0/1",
                 n, net8, busy8, done8, if8.in_ready);
      end
    end
  endtask

  task automatic test_single_pass();
    logic [7:0] pat;
    logic       exp_net;
    pat = 8'hA5;
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre got %b exp 1", if8.in_ready); end
    if8.in_valid = 1'b1; if8.in_data = pat; if8.in_repeat = 4'd0;
    step();
    if8.in_valid = 1'b0;
    // n = cycle index after acceptance, 0 = first SHIFT cycle
    for (int n = 0; n < 12; n++) begin
      exp_net = (n < 8) ? pat[n] : 1'b0;
      checks++;
      if (net8 !== exp_net) begin errors++; $display("FAIL single_net cyc %0d got %b exp %b", n, net8, exp_net); end
      checks++;
      if (done8 !== (n == 10)) begin errors++; $display("FAIL single_done cyc %0d got %b exp %b", n, done8, (n == 10)); end
      checks++;
      if (busy8 !== (n < 10)) begin errors++; $display("FAIL single_busy cyc %0d got %b exp %b", n, busy8, (n < 10)); end
      if (n == 10) begin
        checks++; if (err8 !== 8'd0) begin errors++; $display("FAIL single_err got %0d exp 0", err8); end
      end
      step();
    end
  endtask

  task automatic test_repeat();
    logic exp_net;
    if8.in_valid = 1'b1; if8.in_data = 8'h01; if8.in_repeat = 4'd2;
    step();
    if8.in_valid = 1'b0;
    for (int n = 0; n < 28; n++) begin
      exp_net = (n < 24) && ((n % 8) == 0);
      checks++;
      if (net8 !== exp_net) begin errors++; $display("FAIL repeat_net cyc %0d got %b exp %b", n, net8, exp_net); end
      checks++;
      if (if8.in_ready !== (n >= 26)) begin errors++; $display("FAIL repeat_ready cyc %0d got %b exp %b", n, if8.in_ready, (n >= 26)); end
      checks++;
      if (done8 !== (n == 26)) begin errors++; $display("FAIL repeat_done cyc %0d got %b exp %b", n, done8, (n == 26)); end
      step();
    end
  endtask

  task automatic test_loopback();
    int  n;
    bit  seen;
    fb8_force = 1'b1; fb8_val = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if8.in_valid = 1'b1; if8.in_data = 8'hFF; if8.in_repeat = 4'd15;
      step();
      if8.in_valid = 1'b0;
      checks++; if (err8 !== 8'd0) begin errors++; $display("FAIL loop_clear burst %0d got %0d exp 0", b, err8); end
      seen = 1'b0;
      for (n = 0; n < 300; n++) begin
        if (done8 === 1'b1) begin seen = 1'b1; break; end
        step();
      end
      checks++; if (!seen || n != 130) begin errors++; $display("FAIL loop_done_time burst %0d got %0d exp 130", b, n); end
      checks++; if (err8 !== 8'd128) begin errors++; $display("FAIL loop_err burst %0d got %0d exp 128", b, err8); end
      step();
      checks++; if (err8 !== 8'd128) begin errors++; $display("FAIL loop_hold burst %0d got %0d exp 128", b, err8); end
    end
    fb8_force = 1'b0;

    // 512 mismatches on the 32-bit instance must saturate at 255.
    if32.in_valid = 1'b1; if32.in_data = 32'hFFFF_FFFF; if32.in_repeat = 4'd15;
    step();
    if32.in_valid = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 700; n++) begin
      if (done32 === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    checks++; if (!seen || n != 514) begin errors++; $display("FAIL sat_done_time got %0d exp 514", n); end
    checks++; if (err32 !== 8'd255) begin errors++; $display("FAIL sat_err got %0d exp 255", err32); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1, w2;
    int         n;
    bit         seen;
    w1 = 8'h3C; w2 = 8'hC3;
    if8.in_valid = 1'b1; if8.in_data = w1; if8.in_repeat = 4'd0;
    step();
    if8.in_data = w2;  // second queued word stays offered through the whole burst
    for (n = 0; n < 11; n++) begin
      if (n < 10) begin
        checks++;
        if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp 0", n, if8.in_ready); end
        checks++;
        if (net8 !== ((n < 8) ? w1[n] : 1'b0)) begin
          errors++; $display("FAIL b2b_w1 cyc %0d got %b exp %b", n, net8, (n < 8) ? w1[n] : 1'b0);
        end
      end else begin
        checks++;
        if (done8 !== 1'b1 || if8.in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_done got done=%b rdy=%b exp 1/1", done8, if8.in_ready);
        end
      end
      step();
    end
    // w2 accepted at the done edge: no idle cycle before its first bit.
    for (n = 0; n < 8; n++) begin
      if (n == 1) if8.in_valid = 1'b0;
      checks++;
      if (busy8 !== 1'b1 || net8 !== w2[n]) begin
        errors++; $display("FAIL b2b_w2 cyc %0d got busy=%b net=%b exp 1/%b", n, busy8, net8, w2[n]);
      end
      step();
    end
    seen = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (done8 === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    checks++; if (!seen || n != 2) begin errors++; $display("FAIL b2b_w2_done got %0d exp 2", n); end
    step();
  endtask

  task automatic test_gap0();
    logic [7:0] w1, w2;
    int         n;
    bit         seen;
    w1 = 8'h80; w2 = 8'h01;
    ifg0.in_valid = 1'b1; ifg0.in_data = w1; ifg0.in_repeat = 4'd0;
    step();
    ifg0.in_data = w2;
    for (n = 0; n < 8; n++) begin
      checks++;
      if (netg0 !== w1[n]) begin errors++; $display("FAIL g0_w1 cyc %0d got %b exp %b", n, netg0, w1[n]); end
      step();
    end
    checks++;
    if (doneg0 !== 1'b1 || netg0 !== 1'b0 || ifg0.in_ready !== 1'b1) begin
      errors++; $display("FAIL g0_idle got done=%b net=%b rdy=%b exp 1/0/1", doneg0, netg0, ifg0.in_ready);
    end
    step();
    ifg0.in_valid = 1'b0;
    checks++;
    if (netg0 !== 1'b1 || busyg0 !== 1'b1) begin
      errors++; $display("FAIL g0_w2_first got net=%b busy=%b exp 1/1", netg0, busyg0);
    end
    seen = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (doneg0 === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    checks++; if (!seen || n != 8) begin errors++; $display("FAIL g0_w2_done got %0d exp 8", n); end
    checks++; if (errg0 !== 8'd0) begin errors++; $display("FAIL g0_err got %0d exp 0", errg0); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    fb8_force = 1'b1; fb8_val = 1'b0;
    if8.in_valid = 1'b1; if8.in_data = 8'hFF; if8.in_repeat = 4'd0;
    step();
    if8.in_valid = 1'b0;
    repeat (3) step();
    // 4th SHIFT cycle: three mismatches already counted
    checks++; if (err8 !== 8'd3) begin errors++; $display("FAIL mid_err_pre got %0d exp 3", err8); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (net8 !== 1'b0 || busy8 !== 1'b0 || if8.in_ready !== 1'b1 || err8 !== 8'd0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got net=%b busy=%b rdy=%b err=%0d done=%b exp 0/0/1/0/0",
               net8, busy8, if8.in_ready, err8, done8);
    end
    saw_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL mid_no_done got activity=1 exp 0"); end
    fb8_force = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    fb8_force = 1'b0; fb8_val = 1'b0; fb32 = 1'b0;
    if8.in_valid = 1'b0;  if8.in_data = '0;  if8.in_repeat = 4'd0;
    if32.in_valid = 1'b0; if32.in_data = '0; if32.in_repeat = 4'd0;
    ifg0.in_valid = 1'b0; ifg0.in_data = '0; ifg0.in_repeat = 4'd0;
    #2;
    test_reset();
    test_single_pass();
    test_repeat();
    test_loopback();
    test_back_to_back();
    test_gap0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
